// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: request codes, FSM encoding and byte width shared with the core.
package mem_responder_pkg;
  localparam int BYTE_LEN = 8;
  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_IF    = 2'b01;
  localparam logic [1:0] MEM_LOAD  = 2'b10;
  localparam logic [1:0] MEM_STORE = 2'b11;
  typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, DONE} state_t;
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: core-to-memory request/response bundle.
interface mem_responder_if #(
  parameter int LEN = 32,
  parameter int ADDR_WIDTH = 17
);
  logic                  rdy_in;
  logic [1:0]            mem_vis_stage_state;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LEN-1:0]        write_data;
  logic [LEN-1:0]        mem_data;
  logic                  mem_done;
  modport master (
    output rdy_in, mem_vis_stage_state, mem_addr, write_data,
    input  mem_data, mem_done
  );
  modport slave (
    input  rdy_in, mem_vis_stage_state, mem_addr, write_data,
    output mem_data, mem_done
  );
endinterface

// File: rtl/mem_responder_byte_ram.sv
// byte_ram: byte-wide RAM with synchronous write and one-cycle registered read.
module byte_ram
  import mem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BYTE_LEN-1:0]   wdata,
  output logic [BYTE_LEN-1:0]   rdata
);
  logic [BYTE_LEN-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: serializes 32-bit fetch/load/store requests into four byte RAM accesses.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LEN = 32,
  parameter int ADDR_WIDTH = 17
) (
  input logic clk,
  input logic rst,
  mem_responder_if.slave bus
);
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN-1:0] wdata;
  logic [2:0][BYTE_LEN-1:0] cap;
  logic [BYTE_LEN-1:0] rdata;
  logic re, we;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: if (bus.mem_vis_stage_state != MEM_NONE) begin
        state_n = bus.mem_vis_stage_state == MEM_STORE ? WR : RD;
        cnt_n = 2'd0;
      end
      RD: begin
        state_n = cnt == 2'd3 ? RD_LAST : RD;
        cnt_n = cnt + 2'd1;
      end
      RD_LAST: state_n = DONE;
      WR: begin
        state_n = cnt == 2'd3 ? DONE : WR;
        cnt_n = cnt + 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  // Enables are gated here so a stall leaves RAM output untouched.
  assign re = bus.rdy_in && state == RD;
  assign we = bus.rdy_in && state == WR;
  assign bus.mem_done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      base <= '0;
      wdata <= '0;
      cap <= '0;
      bus.mem_data <= '0;
    end else if (bus.rdy_in) begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE) begin
        base <= bus.mem_addr;
        wdata <= bus.write_data;
      end
      // RAM output lags the address by one cycle, so lane cnt-1 is on rdata now.
      if (state == RD && cnt != 2'd0) cap[cnt - 2'd1] <= rdata;
      if (state == RD_LAST) bus.mem_data <= {rdata, cap};
    end
  end
  byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .re    (re),
    .we    (we),
    .addr  (base + ADDR_WIDTH'(cnt)),
    .wdata (wdata[BYTE_LEN*cnt +: BYTE_LEN]),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random requests checked against a byte-map model.
module tb_mem_responder;
  import mem_responder_pkg::*;
  typedef struct {
    logic [1:0]  code;
    logic [16:0] addr;
    logic [31:0] data;
    int          stall;
  } req_t;
  logic clk = 0;
  logic rst = 1;
  int vectors = 0;
  int miscompares = 0;
  logic [7:0] mdl [logic [16:0]];
  logic [31:0] last_rd = 0;
  logic [16:0] bases [$];
  req_t reqs [$];
  mem_responder_if #(.LEN(32), .ADDR_WIDTH(17)) bus ();
  mem_responder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] model_word(input logic [16:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mdl[a + 17'(i)];
    return w;
  endfunction
  task automatic drive(input req_t r);
    bus.mem_vis_stage_state = r.code;
    bus.mem_addr = r.addr;
    bus.write_data = r.data;
    bus.rdy_in = 1;
  endtask
  task automatic add(input logic [1:0] c, input logic [16:0] a, input logic [31:0] d, input int s);
    req_t r;
    r.code = c; r.addr = a; r.data = d; r.stall = s;
    reqs.push_back(r);
  endtask
  // Runs the queued requests back to back: each next request is presented on mem_done.
  task automatic run_reqs();
    int n, stalls;
    req_t r;
    logic [16:0] a;
    @(negedge clk);
    drive(reqs[0]);
    for (int idx = 0; idx < reqs.size(); idx++) begin
      r = reqs[idx];
      @(posedge clk);
      n = 0;
      stalls = 0;
      while (n < 40) begin
        @(negedge clk);
        if (bus.mem_done) break;
        chk("mem_data_hold", bus.mem_data, last_rd);
        bus.rdy_in = r.stall == 1 ? ($urandom_range(0, 3) != 0) :
                     r.stall == 2 ? !(n >= 3 && n <= 5) : 1'b1;
        if (!bus.rdy_in) stalls++;
        n++;
      end
      chk("latency", 32'(n), 32'((r.code == MEM_STORE ? 4 : 5) + stalls));
      if (r.code == MEM_STORE) begin
        for (int i = 0; i < 4; i++) begin
          a = r.addr + 17'(i);
          mdl[a] = r.data[8*i +: 8];
          chk("ram_byte", 32'(dut.u_ram.mem[a]), 32'(mdl[a]));
        end
        bases.push_back(r.addr);
      end else begin
        last_rd = model_word(r.addr);
        chk("read_word", bus.mem_data, last_rd);
      end
      bus.rdy_in = 1;
      if (idx + 1 < reqs.size()) drive(reqs[idx + 1]);
      else bus.mem_vis_stage_state = MEM_NONE;
      @(negedge clk);
      chk("done_width", 32'(bus.mem_done), 32'd0);
    end
    reqs.delete();
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.rdy_in = 1;
    bus.mem_vis_stage_state = MEM_NONE;
    bus.mem_addr = 0;
    bus.write_data = 0;
    repeat (3) @(negedge clk);
    chk("reset_data", bus.mem_data, 32'd0);
    chk("reset_done", 32'(bus.mem_done), 32'd0);
    rst = 0;
    add(MEM_STORE, 17'h00100, 32'hDEADBEEF, 0);
    run_reqs();
    chk("byte_100", 32'(dut.u_ram.mem[17'h100]), 32'hEF);
    chk("byte_103", 32'(dut.u_ram.mem[17'h103]), 32'hDE);
    add(MEM_LOAD, 17'h00100, 0, 0);
    run_reqs();
    chk("load_deadbeef", bus.mem_data, 32'hDEADBEEF);
    add(MEM_STORE, 17'h00000, 32'h00000013, 0);
    add(MEM_IF, 17'h00000, 0, 0);
    run_reqs();
    chk("fetch_13", bus.mem_data, 32'h00000013);
    add(MEM_STORE, 17'h1FFFE, 32'h11223344, 0);
    run_reqs();
    chk("wrap_1fffe", 32'(dut.u_ram.mem[17'h1FFFE]), 32'h44);
    chk("wrap_1ffff", 32'(dut.u_ram.mem[17'h1FFFF]), 32'h33);
    chk("wrap_00000", 32'(dut.u_ram.mem[17'h00000]), 32'h22);
    chk("wrap_00001", 32'(dut.u_ram.mem[17'h00001]), 32'h11);
    add(MEM_LOAD, 17'h1FFFE, 0, 0);
    run_reqs();
    chk("wrap_reload", bus.mem_data, 32'h11223344);
    add(MEM_STORE, 17'h00300, 32'hCAFEF00D, 0);
    add(MEM_LOAD, 17'h00300, 0, 2);
    run_reqs();
    chk("stall_word", bus.mem_data, 32'hCAFEF00D);
    add(MEM_STORE, 17'h00200, 32'h00000000, 0);
    add(MEM_LOAD, 17'h00100, 0, 0);
    run_reqs();
    @(negedge clk);
    bus.mem_vis_stage_state = MEM_STORE;
    bus.mem_addr = 17'h00200;
    bus.write_data = 32'hAABBCCDD;
    repeat (3) @(posedge clk);
    #1;
    bus.mem_vis_stage_state = MEM_NONE;
    rst = 1;
    #1;
    chk("rst_done", 32'(bus.mem_done), 32'd0);
    chk("rst_data", bus.mem_data, 32'd0);
    @(negedge clk);
    rst = 0;
    mdl[17'h200] = 8'hDD;
    mdl[17'h201] = 8'hCC;
    last_rd = 0;
    repeat (3) @(negedge clk);
    chk("rst_byte_200", 32'(dut.u_ram.mem[17'h200]), 32'hDD);
    chk("rst_byte_201", 32'(dut.u_ram.mem[17'h201]), 32'hCC);
    chk("rst_byte_202", 32'(dut.u_ram.mem[17'h202]), 32'h00);
    chk("rst_byte_203", 32'(dut.u_ram.mem[17'h203]), 32'h00);
    add(MEM_LOAD, 17'h00100, 0, 0);
    add(MEM_STORE, 17'h00400, 32'h5A5AC3C3, 0);
    add(MEM_LOAD, 17'h00400, 0, 0);
    run_reqs();
    chk("b2b_load_b", bus.mem_data, 32'h5A5AC3C3);
    repeat (10) begin
      @(negedge clk);
      chk("no_duplicate", 32'(bus.mem_done), 32'd0);
    end
    for (int k = 0; k < 25; k++) begin
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) begin
        if ($urandom_range(0, 1) == 1)
          add(MEM_STORE, $urandom_range(0, 3) == 0 ? 17'h1FFFC + 17'($urandom_range(0, 3)) : 17'($urandom),
              $urandom, 1);
        else
          add($urandom_range(0, 1) == 1 ? MEM_IF : MEM_LOAD, bases[$urandom_range(0, bases.size() - 1)], 0, 1);
      end
      run_reqs();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
